mem_access_unit: RTL and testbench

Memory-access (MEM) stage of the Chronos RV32I pipeline. It sits directly downstream of the execute stage's EX/MEM latch and upstream of the MEM/WB register. It forms data-memory requests for loads and stores: word-aligned address, byte strobes, lane-replicated store data, and sign/zero-extended load data. A small FSM handles the valid/ready data-memory handshake and stalls the upstream pipeline until each access completes. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : RV32I MEM stage. Forms data-memory requests, runs the valid/ready
//            handshake, extends load data. Optional feature: MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write_en,
    input  logic [2:0]  in_wb_sel,
    output logic        stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write_en,
    output logic [2:0]  out_wb_sel,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_is_mem;
    logic        w_is_store;
    logic        w_mis;
    logic        w_trap;
    logic        w_accept;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_alu;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_rwe;
    logic [2:0]  r_wb_sel;

    // A request with both read and write set is a store.
    assign w_is_mem   = in_mem_read | in_mem_write;
    assign w_is_store = in_mem_write;

`ifdef MISALIGN_TRAP_EN
    logic w_half;
    logic w_word;

    always_comb begin
        w_half = (in_funct3 == 3'b001) || (!w_is_store && (in_funct3 == 3'b101));
        w_word = w_is_store ? (in_funct3[2] | in_funct3[1]) : in_funct3[1];
        w_mis  = (w_half && in_alu_result[0]) ||
                 (w_word && (in_alu_result[1:0] != 2'b00));
    end
`else
    assign w_mis = 1'b0;
`endif

    assign w_trap   = in_valid & w_is_mem & w_mis;
    assign w_accept = in_valid & w_is_mem & ~w_mis;

    // Store lane formation; offset bits below natural alignment are ignored.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = in_store_data;
        case (in_funct3)
            3'b000: begin
                w_wstrb = 4'b0001 << in_alu_result[1:0];
                w_wdata = {4{in_store_data[7:0]}};
            end
            3'b001: begin
                w_wstrb = in_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{in_store_data[15:0]}};
            end
            default: ;
        endcase
        if (!w_is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall        = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we             <= 1'b0;
            r_wdata          <= 32'd0;
            r_wstrb          <= 4'd0;
            r_alu            <= 32'd0;
            r_funct3         <= 3'd0;
            r_rd             <= 5'd0;
            r_rwe            <= 1'b0;
            r_wb_sel         <= 3'd0;
            out_valid        <= 1'b0;
            out_data         <= 32'd0;
            out_rd           <= 5'd0;
            out_reg_write_en <= 1'b0;
            out_wb_sel       <= 3'd0;
            out_misalign     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= w_is_store;
                        r_wdata  <= w_wdata;
                        r_wstrb  <= w_wstrb;
                        r_alu    <= in_alu_result;
                        r_funct3 <= in_funct3;
                        r_rd     <= in_rd;
                        r_rwe    <= in_reg_write_en;
                        r_wb_sel <= in_wb_sel;
                    end else if (in_valid) begin
                        // Non-memory op or trapped misaligned access.
                        out_valid        <= 1'b1;
                        out_data         <= in_alu_result;
                        out_rd           <= in_rd;
                        out_reg_write_en <= in_reg_write_en & ~w_trap;
                        out_wb_sel       <= in_wb_sel;
                        out_misalign     <= w_trap;
                    end
                end
                S_WAIT: begin
                    if (dmem_rsp_valid) begin
                        out_valid        <= 1'b1;
                        out_data         <= r_we ? r_alu
                                                 : load_extend(r_funct3, r_alu[1:0], dmem_rsp_rdata);
                        out_rd           <= r_rd;
                        out_reg_write_en <= r_rwe;
                        out_wb_sel       <= r_wb_sel;
                        out_misalign     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = {r_alu[31:2], 2'b00};
    assign dmem_req_wdata = r_wdata;
    assign dmem_req_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_reg_write_en;
    logic [2:0]  in_wb_sel;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_reg_write_en;
    logic [2:0]  out_wb_sel;
    logic        out_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit u_dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_alu_result    (in_alu_result),
        .in_store_data    (in_store_data),
        .in_mem_read      (in_mem_read),
        .in_mem_write     (in_mem_write),
        .in_funct3        (in_funct3),
        .in_rd            (in_rd),
        .in_reg_write_en  (in_reg_write_en),
        .in_wb_sel        (in_wb_sel),
        .stall            (stall),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_wstrb   (dmem_req_wstrb),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rsp_rdata   (dmem_rsp_rdata),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_rd           (out_rd),
        .out_reg_write_en (out_reg_write_en),
        .out_wb_sel       (out_wb_sel),
        .out_misalign     (out_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: byte/halfword/word rules expressed as arithmetic.
    function automatic logic [31:0] m_wstrb(input logic wr, input logic [2:0] f3,
                                            input logic [31:0] a);
        if (!wr)      return 32'd0;
        if (f3 == 3'd0) return 32'd1 << (a % 4);
        if (f3 == 3'd1) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int unsigned off;
        logic [31:0] sh;
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4)      off = a % 4;
        else if (f3 == 3'd1 || f3 == 3'd5) off = ((a % 4) / 2) * 2;
        else                                off = 0;
        sh = word >> (8 * off);
        case (f3)
            3'd0: begin v = sh & 32'hFF;   return (v >= 32'd128)   ? (v | 32'hFFFFFF00) : v; end
            3'd1: begin v = sh & 32'hFFFF; return (v >= 32'd32768) ? (v | 32'hFFFF0000) : v; end
            3'd4: return sh & 32'hFF;
            3'd5: return sh & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    function automatic bit m_mis(input logic wr, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        bit half;
        bit word;
        half = wr ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
        word = wr ? (f3 >= 3'd2) : (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        return (half && (a % 2 != 0)) || (word && (a % 4 != 0));
`else
        return (wr && !wr) || (f3 != f3) || (a != a);
`endif
    endfunction

    task automatic do_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic rwe, input logic [2:0] wbs,
                         input int rdy_wait, input int rsp_wait,
                         output logic [31:0] got_data);
        bit mem;
        bit mis;
        logic [31:0] exp_data;
        mem      = rd_op || wr_op;
        mis      = mem && m_mis(wr_op, f3, alu);
        exp_data = (mem && !wr_op && !mis) ? m_load(f3, alu, rdata) : alu;

        @(posedge clk); #1;
        in_valid        = 1'b1;
        in_alu_result   = alu;
        in_store_data   = sd;
        in_mem_read     = rd_op;
        in_mem_write    = wr_op;
        in_funct3       = f3;
        in_rd           = rd;
        in_reg_write_en = rwe;
        in_wb_sel       = wbs;
        @(negedge clk);
        check1("stall_accept", stall, mem && !mis);
        check1("reqv_accept", dmem_req_valid, 1'b0);

        if (mem && !mis) begin
            for (int i = 0; i <= rdy_wait; i++) begin
                @(posedge clk); #1;
                dmem_req_ready = (i == rdy_wait);
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check1("reqv_req", dmem_req_valid, 1'b1);
                check1("stall_req", stall, 1'b1);
                check1("we_req", dmem_req_we, wr_op);
                check("addr_req", dmem_req_addr, alu & 32'hFFFFFFFC);
                check("wstrb_req", {28'd0, dmem_req_wstrb}, m_wstrb(wr_op, f3, alu));
                if (wr_op) check("wdata_req", dmem_req_wdata, m_wdata(f3, sd));
                check1("outv_req", out_valid, 1'b0);
            end
            for (int i = 0; i <= rsp_wait; i++) begin
                @(posedge clk); #1;
                dmem_req_ready = 1'($urandom_range(0, 1));
                dmem_rsp_valid = (i == rsp_wait);
                dmem_rsp_rdata = (i == rsp_wait) ? rdata : $urandom;
                @(negedge clk);
                check1("stall_wait", stall, i != rsp_wait);
                check1("reqv_wait", dmem_req_valid, 1'b0);
                check1("outv_wait", out_valid, 1'b0);
            end
        end

        @(posedge clk); #1;
        in_valid       = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        check1("outv", out_valid, 1'b1);
        check("out_data", out_data, exp_data);
        check("out_rd", {27'd0, out_rd}, {27'd0, rd});
        check1("out_rwe", out_reg_write_en, rwe && !mis);
        check("out_wb_sel", {29'd0, out_wb_sel}, {29'd0, wbs});
        check1("out_misalign", out_misalign, mis);
        got_data = out_data;

        @(posedge clk); #1;
        @(negedge clk);
        check1("outv_once", out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] got;
        rst             = 1'b0;
        in_valid        = 1'b0;
        in_alu_result   = 32'd0;
        in_store_data   = 32'd0;
        in_mem_read     = 1'b0;
        in_mem_write    = 1'b0;
        in_funct3       = 3'd0;
        in_rd           = 5'd0;
        in_reg_write_en = 1'b0;
        in_wb_sel       = 3'd0;
        dmem_req_ready  = 1'b0;
        dmem_rsp_valid  = 1'b0;
        dmem_rsp_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check1("rst_stall", stall, 1'b0);
        check1("rst_reqv", dmem_req_valid, 1'b0);
        check1("rst_outv", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check1("rst_misalign", out_misalign, 1'b0);
        check("rst_wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
        check1("rst_we", dmem_req_we, 1'b0);

        // ADD pass-through
        do_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 32'h0, 5'd3, 1'b1, 3'd1, 0, 0, got);
        check("add_data", got, 32'h00001234);
        // LB / LBU, zero-wait memory
        do_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80AABBCC, 5'd4, 1'b1, 3'd2, 0, 0, got);
        check("lb_data", got, 32'hFFFFFF80);
        do_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80AABBCC, 5'd5, 1'b1, 3'd2, 0, 0, got);
        check("lbu_data", got, 32'h00000080);
        // SH with ready held low for 3 cycles
        do_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 5'd0, 1'b0, 3'd0, 3, 0, got);
        // LW with response delayed 4 cycles
        do_op(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 5'd17, 1'b1, 3'd5, 0, 4, got);
        check("lw_data", got, 32'hCAFEF00D);
        // LW at 0x102
        do_op(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h13572468, 5'd9, 1'b1, 3'd2, 0, 0, got);
`ifndef MISALIGN_TRAP_EN
        check("lw_unaligned", got, 32'h13572468);
`endif

        // Reset while in WAIT; a later stray response must be ignored
        @(posedge clk); #1;
        in_valid      = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_write  = 1'b0;
        in_funct3     = 3'd2;
        in_alu_result = 32'h400;
        @(posedge clk); #1;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        rst            = 1'b0;
        @(negedge clk);
        check1("wait_stall", stall, 1'b1);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check1("rstw_stall", stall, 1'b0);
        check1("rstw_reqv", dmem_req_valid, 1'b0);
        check1("rstw_outv", out_valid, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check1("stray_stall", stall, 1'b0);
        check1("stray_reqv", dmem_req_valid, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        check1("stray_outv", out_valid, 1'b0);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            do_op(kind == 1 || kind == 3, kind >= 2, 3'($urandom), $urandom, $urandom,
                  $urandom, 5'($urandom), 1'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
